// File: rtl/memory_ctrl_pkg.sv
// Shared types and default sizes for the memory_ctrl front end and the
// byte-wide address-latched MEMORY array it sequences.
package memory_ctrl_pkg;

  localparam int DEF_SIZE  = 20;
  localparam int DEF_LEN_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WDAT = 3'd1,
    LOAD = 3'd2,
    WR   = 3'd3,
    RD   = 3'd4,
    RSP  = 3'd5
  } state_t;

  function automatic logic is_last_beat(input logic [DEF_LEN_W-1:0] beats);
    return (beats == {DEF_LEN_W{1'b0}});
  endfunction

endpackage

// File: rtl/memory_ctrl.sv
// Burst request front end for the address-latched MEMORY array: one FSM,
// a beat counter, an address register and a data register; owns DATA.
module memory_ctrl
  import memory_ctrl_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [SIZE-1:0]  req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wvalid,
  input  logic [7:0]       wdata,
  output logic             wready,
  output logic             rvalid,
  output logic [7:0]       rdata,
  output logic             rlast,
  input  logic             rready,
  output logic             busy,
  output logic [SIZE-1:0]  ADDRESS,
  output logic             load,
  output logic             write,
  output logic             OE,
  inout  wire  [7:0]       DATA
);

  state_t           state_r;
  state_t           state_s;
  logic [SIZE-1:0]  addr_r;
  logic [LEN_W-1:0] beats_r;
  logic             is_write_r;
  logic [7:0]       wbyte_r;
  logic [7:0]       rdata_r;
  logic             last_s;

  assign last_s = (beats_r == {LEN_W{1'b0}});

  // Next-state decode; only the current state and handshake inputs steer it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = req_write ? WDAT : LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      WDAT: begin
        if (wvalid) begin
          state_s = LOAD;
        end else begin
          state_s = WDAT;
        end
      end
      LOAD: begin
        state_s = is_write_r ? WR : RD;
      end
      WR: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = WDAT;
        end
      end
      RD: begin
        state_s = RSP;
      end
      RSP: begin
        if (rready) begin
          state_s = last_s ? IDLE : LOAD;
        end else begin
          state_s = RSP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, burst bookkeeping and data registers; reset abandons any burst.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      addr_r     <= {SIZE{1'b0}};
      beats_r    <= {LEN_W{1'b0}};
      is_write_r <= 1'b0;
      wbyte_r    <= 8'h00;
      rdata_r    <= 8'h00;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r     <= req_addr;
            beats_r    <= req_len;
            is_write_r <= req_write;
          end
        end
        WDAT: begin
          if (wvalid) begin
            wbyte_r <= wdata;
          end
        end
        WR: begin
          // Address wraps modulo 2^SIZE through natural overflow.
          addr_r <= addr_r + SIZE'(1);
          if (!last_s) begin
            beats_r <= beats_r - LEN_W'(1);
          end
        end
        RD: begin
          rdata_r <= DATA;
        end
        RSP: begin
          if (rready && !last_s) begin
            addr_r  <= addr_r + SIZE'(1);
            beats_r <= beats_r - LEN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign wready    = (state_r == WDAT);
  assign load      = (state_r == LOAD);
  assign write     = (state_r == WR);
  assign OE        = (state_r == RD);
  assign rvalid    = (state_r == RSP);
  assign rlast     = (state_r == RSP) && last_s;
  assign rdata     = rdata_r;
  assign ADDRESS   = addr_r;
  assign DATA      = (state_r == WR) ? wbyte_r : 8'hzz;

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench for memory_ctrl with a behavioural MEMORY array attached.
module tb_memory_ctrl;
  import memory_ctrl_pkg::*;

  localparam int SIZE  = DEF_SIZE;
  localparam int LEN_W = DEF_LEN_W;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [SIZE-1:0]  req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic             wvalid = 1'b0;
  logic [7:0]       wdata = 8'h00;
  logic             wready;
  logic             rvalid;
  logic [7:0]       rdata;
  logic             rlast;
  logic             rready = 1'b1;
  logic             busy;
  logic [SIZE-1:0]  ADDRESS;
  logic             load;
  logic             write;
  logic             OE;
  wire  [7:0]       DATA;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int rvalid_seen = 0;

  logic [7:0]      mem [0:(1<<SIZE)-1];
  logic [SIZE-1:0] mem_addr;
  logic [SIZE-1:0] wr_log [$];

  memory_ctrl #(.SIZE(SIZE), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready),
    .busy(busy), .ADDRESS(ADDRESS), .load(load), .write(write), .OE(OE),
    .DATA(DATA)
  );

  always #5 CLK = ~CLK;

  // MEMORY model: address latched on load, byte stored on write, driven on OE.
  always @(posedge CLK) begin
    if (load) mem_addr <= ADDRESS;
    if (write) begin
      mem[mem_addr] <= DATA;
      wr_log.push_back(mem_addr);
      wr_count = wr_count + 1;
    end
  end
  assign DATA = OE ? mem[mem_addr] : 8'hzz;

  // Bus contention watch on every cycle outside reset.
  always @(negedge CLK) begin
    if (!RESET) begin
      tests = tests + 1;
      if ((OE && write) !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL contention: OE=%b write=%b required not both 1", OE, write);
      end
      if (rvalid) rvalid_seen = rvalid_seen + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    tests++;
    if ({busy, wready, rvalid, rlast, load, write, OE} !== 7'b0) begin
      fails++; $display("FAIL reset_ctl: got %b required 0000000", {busy, wready, rvalid, rlast, load, write, OE});
    end
    tests++;
    if (rdata !== 8'h00 || ADDRESS !== 20'h00000) begin
      fails++; $display("FAIL reset_regs: rdata=%h ADDRESS=%h required 00/00000", rdata, ADDRESS);
    end
    RESET = 1'b0;
    tick();
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_single_write_read();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00010; req_len = 4'd0;
    wvalid = 1'b1; wdata = 8'h3C;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL sw_c0: req_ready=%b required 1", req_ready); end
    tick(); req_valid = 1'b0;
    tests++;
    if ({wready, load, write} !== 3'b100) begin
      fails++; $display("FAIL sw_c1: wready/load/write=%b required 100", {wready, load, write});
    end
    tick(); wvalid = 1'b0;
    tests++;
    if (load !== 1'b1 || ADDRESS !== 20'h00010 || write !== 1'b0) begin
      fails++; $display("FAIL sw_c2: load=%b ADDRESS=%h write=%b required 1/00010/0", load, ADDRESS, write);
    end
    tick();
    tests++;
    if (write !== 1'b1 || DATA !== 8'h3C || OE !== 1'b0) begin
      fails++; $display("FAIL sw_c3: write=%b DATA=%h OE=%b required 1/3c/0", write, DATA, OE);
    end
    tick();
    tests++;
    if (req_ready !== 1'b1 || write !== 1'b0 || mem[20'h00010] !== 8'h3C) begin
      fails++; $display("FAIL sw_c4: req_ready=%b write=%b mem=%h required 1/0/3c", req_ready, write, mem[20'h00010]);
    end
    req_valid = 1'b1; req_write = 1'b0; rready = 1'b1;
    tick(); req_valid = 1'b0;
    tests++;
    if (load !== 1'b1 || ADDRESS !== 20'h00010) begin
      fails++; $display("FAIL sr_c1: load=%b ADDRESS=%h required 1/00010", load, ADDRESS);
    end
    tick();
    tests++;
    if (OE !== 1'b1 || rvalid !== 1'b0) begin
      fails++; $display("FAIL sr_c2: OE=%b rvalid=%b required 1/0", OE, rvalid);
    end
    tick();
    tests++;
    if ({rvalid, rlast} !== 2'b11 || rdata !== 8'h3C) begin
      fails++; $display("FAIL sr_c3: rvalid/rlast=%b rdata=%h required 11/3c", {rvalid, rlast}, rdata);
    end
    tick();
    tests++;
    if (rvalid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL sr_c4: rvalid=%b req_ready=%b required 0/1", rvalid, req_ready);
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0]      wb [4];
    logic [SIZE-1:0] wa [4];
    int n;
    int k;
    wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33; wb[3] = 8'h44;
    wa[0] = 20'hFFFFE; wa[1] = 20'hFFFFF; wa[2] = 20'h00000; wa[3] = 20'h00001;
    wr_log.delete();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'hFFFFE; req_len = 4'd3;
    wvalid = 1'b1; wdata = wb[0];
    k = 0;
    tick(); req_valid = 1'b0; n = 1;
    while (busy && n < 40) begin
      if (write) begin
        k++;
        if (k < 4) wdata = wb[k];
      end
      tick(); n++;
    end
    wvalid = 1'b0;
    tests++;
    if (n !== 13 || k !== 4) begin
      fails++; $display("FAIL bw_timing: cycles=%0d beats=%0d required 13/4", n, k);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wr_log.size() <= i || wr_log[i] !== wa[i] || mem[wa[i]] !== wb[i]) begin
        fails++; $display("FAIL bw_beat%0d: addr=%h data=%h required %h/%h", i,
                          (wr_log.size() > i) ? wr_log[i] : 20'h0, mem[wa[i]], wa[i], wb[i]);
      end
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'hFFFFE; req_len = 4'd3; rready = 1'b1;
    k = 0;
    tick(); req_valid = 1'b0; n = 1;
    while (busy && n < 40) begin
      if (rvalid) begin
        tests++;
        if (k > 3 || rdata !== wb[k & 3] || rlast !== (k == 3)) begin
          fails++; $display("FAIL br_beat%0d: rdata=%h rlast=%b required %h/%b", k, rdata, rlast, wb[k & 3], (k == 3));
        end
        k++;
      end
      tick(); n++;
    end
    tests++;
    if (n !== 13 || k !== 4) begin
      fails++; $display("FAIL br_timing: cycles=%0d beats=%0d required 13/4", n, k);
    end
  endtask

  task automatic test_backpressure();
    int n;
    rready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'hFFFFE; req_len = 4'd1;
    tick(); req_valid = 1'b0; n = 0;
    while (!rvalid && n < 10) begin tick(); n++; end
    tests++;
    if (rvalid !== 1'b1) begin fails++; $display("FAIL bp_wait: rvalid=%b required 1", rvalid); end
    repeat (5) begin
      tests++;
      if (rvalid !== 1'b1 || rdata !== 8'h11 || load !== 1'b0 || rlast !== 1'b0) begin
        fails++; $display("FAIL bp_hold: rvalid=%b rdata=%h load=%b rlast=%b required 1/11/0/0", rvalid, rdata, load, rlast);
      end
      tick();
    end
    rready = 1'b1;
    tick();
    tests++;
    if (load !== 1'b1 || ADDRESS !== 20'hFFFFF) begin
      fails++; $display("FAIL bp_resume: load=%b ADDRESS=%h required 1/fffff", load, ADDRESS);
    end
    n = 0;
    while (!rvalid && n < 10) begin tick(); n++; end
    tests++;
    if (rvalid !== 1'b1 || rdata !== 8'h22 || rlast !== 1'b1) begin
      fails++; $display("FAIL bp_beat2: rvalid=%b rdata=%h rlast=%b required 1/22/1", rvalid, rdata, rlast);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL bp_done: busy=%b required 0", busy); end
  endtask

  task automatic test_starvation();
    int n;
    wvalid = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00100; req_len = 4'd1;
    tick(); req_valid = 1'b0;
    repeat (4) begin
      tests++;
      if (wready !== 1'b1 || load !== 1'b0 || write !== 1'b0) begin
        fails++; $display("FAIL st_wait: wready=%b load=%b write=%b required 1/0/0", wready, load, write);
      end
      tick();
    end
    wvalid = 1'b1; wdata = 8'hAA;
    tick(); wdata = 8'hBB;
    tests++;
    if (load !== 1'b1 || ADDRESS !== 20'h00100) begin
      fails++; $display("FAIL st_load: load=%b ADDRESS=%h required 1/00100", load, ADDRESS);
    end
    tick();
    tests++;
    if (write !== 1'b1 || DATA !== 8'hAA) begin
      fails++; $display("FAIL st_write: write=%b DATA=%h required 1/aa", write, DATA);
    end
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    wvalid = 1'b0;
    tests++;
    if (busy !== 1'b0 || mem[20'h00100] !== 8'hAA || mem[20'h00101] !== 8'hBB) begin
      fails++; $display("FAIL st_mem: busy=%b mem=%h,%h required 0/aa,bb", busy, mem[20'h00100], mem[20'h00101]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int oe_cnt;
    int rv_mark;
    rready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'hFFFFE; req_len = 4'd3;
    tick(); req_valid = 1'b0;
    n = 0; oe_cnt = 0;
    while (n < 20 && oe_cnt < 2) begin
      if (OE) oe_cnt++;
      if (oe_cnt < 2) begin tick(); n++; end
    end
    tests++;
    if (oe_cnt !== 2 || OE !== 1'b1) begin
      fails++; $display("FAIL rm_reach: rd_count=%0d OE=%b required 2/1", oe_cnt, OE);
    end
    RESET = 1'b1;
    tick();
    tests++;
    if ({busy, wready, rvalid, rlast, load, write, OE} !== 7'b0 || rdata !== 8'h00 || ADDRESS !== 20'h00000) begin
      fails++; $display("FAIL rm_reset: ctl=%b rdata=%h ADDRESS=%h required 0000000/00/00000",
                        {busy, wready, rvalid, rlast, load, write, OE}, rdata, ADDRESS);
    end
    RESET = 1'b0;
    rv_mark = rvalid_seen;
    tick();
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rm_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
    repeat (5) tick();
    tests++;
    if (rvalid_seen !== rv_mark) begin
      fails++; $display("FAIL rm_no_rvalid: rvalid cycles=%0d required 0", rvalid_seen - rv_mark);
    end
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_burst_wrap();
    test_backpressure();
    test_starvation();
    test_reset_mid();
    tests++;
    if (wr_count !== 7) begin
      fails++; $display("FAIL write_total: write pulses=%0d required 7", wr_count);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
